volume_fader: RTL and testbench

Output gain stage between the echo stage and the codec. It takes each signed 16-bit sample from the echo stage and scales it by a 5-bit gain (0..16, unit = 1/16). The gain steps toward a target set by the volume and mute controls at a bounded rate, so volume changes, mute and power-up never produce a step discontinuity. The block emits one registered, scaled sample per input sample, with a one-cycle valid strobe.

---
 rtl/volume_fader_pkg.sv | 8 +
 rtl/volume_fader_if.sv | 19 +
 rtl/volume_fader_gain_ramp.sv | 61 ++++++
 rtl/volume_fader.sv | 44 ++++
 tb/tb_volume_fader.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/volume_fader_pkg.sv
// volume_fader_pkg: widths, gain scaling constants and fader state shared with the echo stage.
package volume_fader_pkg;
    localparam int SAMPLE_W   = 16;
    localparam int GAIN_W     = 5;
    localparam int GAIN_UNITY = 16;
    localparam int GAIN_SHIFT = 4;
    typedef enum logic [1:0] {STEADY, RAMP, MUTED} fader_state_e;
endpackage

// File: rtl/volume_fader_if.sv
// volume_fader_if: sample stream from the echo stage and scaled stream to the codec.
interface volume_fader_if;
    import volume_fader_pkg::*;
    logic signed [SAMPLE_W-1:0] sample_in;
    logic                       new_sample_ready;
    logic [3:0]                 volume;
    logic                       mute;
    logic [SAMPLE_W-1:0]        sample_to_codec;
    logic                       sample_valid;
    logic                       muted;
    modport master (
        output sample_in, new_sample_ready, volume, mute,
        input  sample_to_codec, sample_valid, muted
    );
    modport slave (
        input  sample_in, new_sample_ready, volume, mute,
        output sample_to_codec, sample_valid, muted
    );
endinterface

// File: rtl/volume_fader_gain_ramp.sv
// volume_fader_gain_ramp: sample edge detect, rate-limited gain stepping and fade state machine.
module volume_fader_gain_ramp #(
    parameter int STEP_SAMPLES = 64,
    parameter int GAIN_W       = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              new_sample_ready_i,
    input  logic              mute_i,
    input  logic [GAIN_W-1:0] target_i,
    output logic [GAIN_W-1:0] gain_o,
    output logic              take_o,
    output logic              muted_o
);
    import volume_fader_pkg::*;
    localparam logic [9:0] STEP_LAST = 10'(STEP_SAMPLES - 1);
    fader_state_e      state_q, state_d;
    logic              prev_q;
    logic [9:0]        cnt_q, cnt_d;
    logic [GAIN_W-1:0] gain_q, gain_d;
    logic              at_target;
    assign take_o    = new_sample_ready_i & ~prev_q;
    assign at_target = gain_q == target_i;
    assign gain_o    = gain_q;
    assign muted_o   = state_q == MUTED;
    // Direction is chosen at each step, so a target reversal mid-ramp never overshoots.
    always_comb begin
        gain_d = gain_q;
        cnt_d  = at_target ? '0 : cnt_q;
        if (!at_target && take_o) begin
            if (cnt_q == STEP_LAST) begin
                gain_d = gain_q < target_i ? gain_q + 1'b1 : gain_q - 1'b1;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            STEADY:  if (!at_target) state_d = RAMP;
            RAMP:    if (gain_d == target_i) state_d = target_i == '0 ? MUTED : STEADY;
            MUTED:   if (!mute_i) state_d = RAMP;
            default: state_d = MUTED;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= MUTED;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
            gain_q  <= '0;
        end else begin
            state_q <= state_d;
            prev_q  <= new_sample_ready_i;
            cnt_q   <= cnt_d;
            gain_q  <= gain_d;
        end
    end
endmodule

// File: rtl/volume_fader.sv
// volume_fader: output gain stage; scales each taken sample by a slowly ramped 0..16/16 gain.
module volume_fader #(
    parameter int STEP_SAMPLES = 64,
    parameter int GAIN_W       = 5
) (
    input logic           clk,
    input logic           reset,
    volume_fader_if.slave bus
);
    import volume_fader_pkg::*;
    logic [GAIN_W-1:0]                 target, gain;
    logic                              take;
    logic signed [SAMPLE_W+GAIN_W-1:0] product;
    logic [SAMPLE_W-1:0]               sample_q, sample_d;
    logic                              valid_q;
    assign target = bus.mute ? '0 : GAIN_W'(bus.volume) + 1'b1;
    volume_fader_gain_ramp #(
        .STEP_SAMPLES(STEP_SAMPLES),
        .GAIN_W      (GAIN_W)
    ) u_ramp (
        .clk               (clk),
        .reset             (reset),
        .new_sample_ready_i(bus.new_sample_ready),
        .mute_i            (bus.mute),
        .target_i          (target),
        .gain_o            (gain),
        .take_o            (take),
        .muted_o           (bus.muted)
    );
    // gain is the pre-step register value, so a sample taken on a step cycle uses the old gain.
    assign product  = bus.sample_in * $signed({1'b0, gain});
    assign sample_d = take ? SAMPLE_W'(product >>> GAIN_SHIFT) : sample_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sample_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            sample_q <= sample_d;
            valid_q  <= take;
        end
    end
    assign bus.sample_to_codec = sample_q;
    assign bus.sample_valid    = valid_q;
endmodule

// File: tb/tb_volume_fader.sv
// tb_volume_fader: scoreboarded gain model plus fixed vectors and fade/reset corner sequences.
module tb_volume_fader;
    localparam int STEP = 2;
    typedef struct {
        logic [3:0]  vol;
        logic [15:0] s;
        logic [15:0] exp;
    } vec_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    volume_fader_if vif();
    volume_fader #(.STEP_SAMPLES(STEP)) dut (.clk(clk), .reset(reset), .bus(vif));
    always #5 clk = ~clk;
    vec_t        vecs[12];
    int          checks = 0, failures = 0;
    int          m_gain = 0, m_cnt = 0, pulses = 0;
    logic        m_prev = 1'b0;
    logic [15:0] exp_q[$];
    logic [15:0] last_out;

    function automatic logic [15:0] scale(logic [15:0] s, int g);
        int p;
        p = int'($signed(s)) * g;
        return 16'(p >>> 4);
    endfunction

    task automatic chk(string name, logic [15:0] got, logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic tick();
        logic tk;
        int   tgt;
        tk  = vif.new_sample_ready & ~m_prev;
        tgt = vif.mute ? 0 : int'(vif.volume) + 1;
        if (tk) exp_q.push_back(scale(vif.sample_in, m_gain));
        if (m_gain == tgt) m_cnt = 0;
        else if (tk) begin
            if (m_cnt == STEP - 1) begin
                m_gain += (m_gain < tgt) ? 1 : -1;
                m_cnt = 0;
            end else m_cnt++;
        end
        m_prev = vif.new_sample_ready;
        @(posedge clk);
        #1;
        chk("valid", 16'(vif.sample_valid), 16'(tk));
        if (vif.sample_valid) begin
            pulses++;
            last_out = vif.sample_to_codec;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected got=%h exp=none", vif.sample_to_codec);
            end else chk("sample", vif.sample_to_codec, exp_q.pop_front());
        end
    endtask

    task automatic smp(logic [15:0] s);
        vif.sample_in = s;
        vif.new_sample_ready = 1'b1;
        tick();
        vif.new_sample_ready = 1'b0;
        tick();
    endtask

    initial begin
        vecs[0]  = '{4'd15, 16'h8000, 16'h8000};
        vecs[1]  = '{4'd15, 16'h7FFF, 16'h7FFF};
        vecs[2]  = '{4'd7,  16'hFFFF, 16'hFFFF};
        vecs[3]  = '{4'd7,  16'h0001, 16'h0000};
        vecs[4]  = '{4'd7,  16'h4000, 16'h2000};
        vecs[5]  = '{4'd7,  16'h8000, 16'hC000};
        vecs[6]  = '{4'd0,  16'h7FFF, 16'h07FF};
        vecs[7]  = '{4'd0,  16'h8000, 16'hF800};
        vecs[8]  = '{4'd0,  16'hFFF0, 16'hFFFF};
        vecs[9]  = '{4'd3,  16'h0100, 16'h0040};
        vecs[10] = '{4'd3,  16'hFF01, 16'hFFC0};
        vecs[11] = '{4'd11, 16'h1000, 16'h0C00};
        vif.sample_in = '0;
        vif.new_sample_ready = 1'b0;
        vif.volume = 4'd15;
        vif.mute = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("rst_out", vif.sample_to_codec, 16'h0000);
        chk("rst_valid", 16'(vif.sample_valid), 16'h0000);
        chk("rst_muted", 16'(vif.muted), 16'h0001);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 34; k++) begin
            smp(16'h4000);
            chk("ramp_up", last_out, 16'(32'h400 * (k / 2)));
        end
        chk("muted_after_up", 16'(vif.muted), 16'h0000);
        pulses = 0;
        vif.sample_in = 16'h1234;
        vif.new_sample_ready = 1'b1;
        repeat (10) tick();
        vif.new_sample_ready = 1'b0;
        tick();
        chk("held_pulses", 16'(pulses), 16'd1);
        vif.mute = 1'b1;
        for (int k = 0; k < 32; k++) begin
            smp(16'h4000);
            if (k == 29) chk("muted_before_zero", 16'(vif.muted), 16'h0000);
        end
        chk("muted_at_zero", 16'(vif.muted), 16'h0001);
        for (int k = 0; k < 2; k++) begin
            smp(16'h4000);
            chk("muted_out", last_out, 16'h0000);
        end
        chk("muted_hold", 16'(vif.muted), 16'h0001);
        vif.mute = 1'b0;
        tick();
        chk("unmute", 16'(vif.muted), 16'h0000);
        for (int k = 0; k < 12; k++) begin
            smp(16'h1000);
            chk("ramp_resume", last_out, 16'(32'h100 * (k / 2)));
        end
        vif.volume = 4'd2;
        for (int k = 0; k < 8; k++) begin
            smp(16'h1000);
            chk("reverse", last_out, 16'(32'h100 * (6 - k / 2)));
        end
        smp(16'h1000);
        chk("reverse_steady", last_out, 16'h0300);
        chk("reverse_muted", 16'(vif.muted), 16'h0000);
        vif.volume = 4'd15;
        vif.sample_in = 16'h1000;
        vif.new_sample_ready = 1'b1;
        tick();
        chk("valid_pre_rst", 16'(vif.sample_valid), 16'h0001);
        #1 reset = 1'b0;
        #1;
        chk("arst_out", vif.sample_to_codec, 16'h0000);
        chk("arst_valid", 16'(vif.sample_valid), 16'h0000);
        chk("arst_muted", 16'(vif.muted), 16'h0001);
        vif.new_sample_ready = 1'b0;
        exp_q.delete();
        m_gain = 0;
        m_cnt = 0;
        m_prev = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            int n;
            n = 0;
            vif.volume = vecs[i].vol;
            while (m_gain != int'(vecs[i].vol) + 1 && n < 80) begin
                smp(16'h0000);
                n++;
            end
            if (n >= 80) begin
                checks++;
                failures++;
                $display("FAIL settle vec=%0d got_gain=%0d exp_gain=%0d", i, m_gain, int'(vecs[i].vol) + 1);
            end
            smp(vecs[i].s);
            chk($sformatf("vec%0d", i), last_out, vecs[i].exp);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
